// File: rtl/tt_uio_pkg.sv
// Shared types and constants for the TinyTapeout uio register responder.
// Covers the handshake FSM states, the register map and the ui_in bit layout.
package tt_uio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [2:0] ADDR_CNT    = 3'd6;
    localparam logic [2:0] ADDR_ID     = 3'd7;
    localparam int         NUM_RW_REGS = 6;

    localparam int UI_REQ_BIT   = 7;
    localparam int UI_WR_BIT    = 6;
    localparam int UI_ADDR_MSB  = 2;
    localparam int UI_ADDR_LSB  = 0;

endpackage

// File: rtl/tt_sync2.sv
// Multi-flop synchronizer for asynchronous pin inputs.
// The reset is synchronous and active high.
module tt_sync2 #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // Shift the pin value through the flop chain
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/tt_uio_reg_responder.sv
// Pin-level req/ack register responder: single-byte reads and writes of a small
// register file, with read data returned on the bidirectional uio pins.
module tt_uio_reg_responder
    import tt_uio_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] ID_VALUE    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic       req_s;
    logic       unused_s;
    state_t     state_r;
    state_t     state_nxt_s;
    logic       wr_r;
    logic [2:0] addr_r;
    logic [7:0] wdata_r;
    logic [7:0] regs_r [NUM_RW_REGS];
    logic [7:0] cnt_r;
    logic [7:0] rd_data_s;
    logic [7:0] uio_out_r;
    logic [7:0] uio_oe_r;
    logic       ack_r;

    // ui_in[5:3] carries nothing for this block
    assign unused_s = ^ui_in[5:3];

    tt_sync2 #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (ui_in[UI_REQ_BIT]),
        .q   (req_s)
    );

    // Handshake next-state logic; ena only gates the start of a transaction
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_s && ena) begin
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: state_nxt_s = ACK;
            ACK: begin
                if (!req_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ACK;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Read mux over the register map, using the pre-update values
    always_comb begin
        rd_data_s = 8'h00;
        case (addr_r)
            3'd0:     rd_data_s = regs_r[0];
            3'd1:     rd_data_s = regs_r[1];
            3'd2:     rd_data_s = regs_r[2];
            3'd3:     rd_data_s = regs_r[3];
            3'd4:     rd_data_s = regs_r[4];
            3'd5:     rd_data_s = regs_r[5];
            ADDR_CNT: rd_data_s = cnt_r;
            ADDR_ID:  rd_data_s = ID_VALUE;
            default:  rd_data_s = 8'h00;
        endcase
    end

    // FSM state, request latch, register file, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            wr_r      <= 1'b0;
            addr_r    <= 3'd0;
            wdata_r   <= 8'h00;
            cnt_r     <= 8'h00;
            uio_out_r <= 8'h00;
            uio_oe_r  <= 8'h00;
            ack_r     <= 1'b0;
            for (int i = 0; i < NUM_RW_REGS; i++) begin
                regs_r[i] <= 8'h00;
            end
        end else begin
            state_r <= state_nxt_s;
            if (state_r == IDLE && state_nxt_s == EXEC) begin
                wr_r    <= ui_in[UI_WR_BIT];
                addr_r  <= ui_in[UI_ADDR_MSB:UI_ADDR_LSB];
                wdata_r <= uio_in;
            end
            if (state_r == EXEC) begin
                cnt_r <= cnt_r + 8'd1;
                if (wr_r) begin
                    // Addresses 6 and 7 match no entry, so those writes drop out
                    for (int i = 0; i < NUM_RW_REGS; i++) begin
                        if (addr_r == 3'(i)) begin
                            regs_r[i] <= wdata_r;
                        end
                    end
                end else begin
                    uio_out_r <= rd_data_s;
                end
            end
            ack_r    <= (state_nxt_s == ACK);
            uio_oe_r <= (state_nxt_s == ACK && !wr_r) ? 8'hFF : 8'h00;
        end
    end

    assign uo_out  = {regs_r[0][6:0], ack_r};
    assign uio_out = uio_out_r;
    assign uio_oe  = uio_oe_r;

endmodule

// File: tb/tb_tt_uio_reg_responder.sv
// Directed self-checking bench for tt_uio_reg_responder.
// Host-side tasks drive the 4-phase handshake; each test task checks its own results.
module tb_tt_uio_reg_responder;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks   = 0;
    int failures = 0;

    tt_uio_reg_responder #(
        .SYNC_STAGES (2),
        .ID_VALUE    (8'hA5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hold reset for three edges, then release; caller is #1 after an edge
    task automatic apply_reset();
        rst   = 1'b1;
        ui_in = 8'h00;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    // Raise req with the given op and count edges until ack (bounded)
    task automatic host_req(input logic wr, input logic [2:0] addr,
                            input logic [7:0] wd, output int lat);
        ui_in  = {1'b1, wr, 3'b000, addr};
        uio_in = wd;
        lat    = 0;
        while (lat < 50 && uo_out[0] !== 1'b1) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Drop req and count edges until ack falls (bounded)
    task automatic host_release(output int lat);
        ui_in[7] = 1'b0;
        lat      = 0;
        while (lat < 50 && uo_out[0] !== 1'b0) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        int lat;
        apply_reset();
        checks++;
        if (uo_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_uo_out: got %h want 00", uo_out);
        end
        checks++;
        if (uio_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_uio_out: got %h want 00", uio_out);
        end
        checks++;
        if (uio_oe !== 8'h00) begin
            failures++;
            $display("FAIL reset_uio_oe: got %h want 00", uio_oe);
        end
        host_req(1'b0, 3'd7, 8'h00, lat);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL id_read_latency: got %0d want 4", lat);
        end
        checks++;
        if (uio_out !== 8'hA5) begin
            failures++;
            $display("FAIL id_read_data: got %h want a5", uio_out);
        end
        checks++;
        if (uio_oe !== 8'hFF) begin
            failures++;
            $display("FAIL id_read_oe: got %h want ff", uio_oe);
        end
        host_release(lat);
    endtask

    task automatic test_write_read();
        int lat;
        apply_reset();
        host_req(1'b1, 3'd0, 8'h3C, lat);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL write_latency: got %0d want 4", lat);
        end
        checks++;
        if (uo_out !== 8'h79) begin
            failures++;
            $display("FAIL write_uo_out_ack: got %h want 79", uo_out);
        end
        checks++;
        if (uio_oe !== 8'h00) begin
            failures++;
            $display("FAIL write_uio_oe: got %h want 00", uio_oe);
        end
        host_release(lat);
        checks++;
        if (uo_out !== 8'h78) begin
            failures++;
            $display("FAIL write_uo_out_idle: got %h want 78", uo_out);
        end
        host_req(1'b0, 3'd0, 8'h00, lat);
        checks++;
        if (uio_out !== 8'h3C || uio_oe !== 8'hFF) begin
            failures++;
            $display("FAIL readback_addr0: got data %h oe %h want 3c ff", uio_out, uio_oe);
        end
        host_release(lat);
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("FAIL release_latency: got %0d want 3", lat);
        end
        checks++;
        if (uio_oe !== 8'h00) begin
            failures++;
            $display("FAIL release_uio_oe: got %h want 00", uio_oe);
        end
    endtask

    task automatic test_read_only();
        int lat;
        apply_reset();
        host_req(1'b1, 3'd7, 8'h00, lat);
        host_release(lat);
        host_req(1'b0, 3'd7, 8'h00, lat);
        checks++;
        if (uio_out !== 8'hA5) begin
            failures++;
            $display("FAIL ro_id_after_write: got %h want a5", uio_out);
        end
        host_release(lat);
        host_req(1'b0, 3'd6, 8'h00, lat);
        checks++;
        if (uio_out !== 8'h02) begin
            failures++;
            $display("FAIL ro_counter_advance: got %h want 02", uio_out);
        end
        host_release(lat);
    endtask

    task automatic test_counter_wrap();
        int lat;
        int bad_lat = 0;
        apply_reset();
        for (int i = 0; i < 255; i++) begin
            host_req(1'b1, 3'd1, 8'(i), lat);
            if (lat !== 4) bad_lat++;
            host_release(lat);
        end
        checks++;
        if (bad_lat !== 0) begin
            failures++;
            $display("FAIL wrap_write_latency: got %0d slow writes want 0", bad_lat);
        end
        host_req(1'b0, 3'd6, 8'h00, lat);
        checks++;
        if (uio_out !== 8'hFF) begin
            failures++;
            $display("FAIL counter_255: got %h want ff", uio_out);
        end
        host_release(lat);
        host_req(1'b0, 3'd6, 8'h00, lat);
        checks++;
        if (uio_out !== 8'h00) begin
            failures++;
            $display("FAIL counter_wrap: got %h want 00", uio_out);
        end
        host_release(lat);
        host_req(1'b0, 3'd1, 8'h00, lat);
        checks++;
        if (uio_out !== 8'hFE) begin
            failures++;
            $display("FAIL last_write_addr1: got %h want fe", uio_out);
        end
        host_release(lat);
    endtask

    task automatic test_ena_gating();
        int lat;
        int seen_ack = 0;
        apply_reset();
        ena   = 1'b0;
        ui_in = {1'b1, 1'b0, 3'b000, 3'd7};
        repeat (10) begin
            @(posedge clk);
            #1;
            if (uo_out[0] !== 1'b0) seen_ack++;
        end
        checks++;
        if (seen_ack !== 0) begin
            failures++;
            $display("FAIL ena_gated_ack: got %0d ack cycles want 0", seen_ack);
        end
        ena = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (uo_out[0] !== 1'b0) begin
            failures++;
            $display("FAIL ena_edge1_ack: got %b want 0", uo_out[0]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (uo_out[0] !== 1'b1 || uio_out !== 8'hA5) begin
            failures++;
            $display("FAIL ena_edge2_ack: got ack %b data %h want 1 a5", uo_out[0], uio_out);
        end
        host_release(lat);
    endtask

    task automatic test_mid_reset();
        int lat;
        apply_reset();
        host_req(1'b1, 3'd0, 8'h55, lat);
        checks++;
        if (lat !== 4 || uo_out !== 8'hAB) begin
            failures++;
            $display("FAIL mid_write_ack: got lat %0d uo_out %h want 4 ab", lat, uo_out);
        end
        rst   = 1'b1;
        ui_in = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (uo_out !== 8'h00 || uio_oe !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset_outputs: got uo_out %h oe %h want 00 00", uo_out, uio_oe);
        end
        host_req(1'b0, 3'd0, 8'h00, lat);
        checks++;
        if (lat !== 4 || uio_out !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset_readback: got lat %0d data %h want 4 00", lat, uio_out);
        end
        host_release(lat);
    endtask

    initial begin
        rst    = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_read_only();
        test_counter_wrap();
        test_ena_gating();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tt_uio_reg_responder.md
# tt_uio_reg_responder

Pin-level register responder for a TinyTapeout user project. An external host drives a 4-phase req/ack handshake on `ui_in` and bidirectional data on `uio`. The block serves single-byte reads and writes of a small register file and returns read data by driving `uio_out`/`uio_oe`. It sits directly behind the `tt_um_*` top wrapper, and the top wrapper inverts `rst_n` into `rst`.

## Interface
- `SYNC_STAGES`, 2: flops in the `req` synchronizer (≥2).
- `ID_VALUE`, 8'hA5: read-only value at address 7.

Ports:
- `clk` input 1: the single clock.
- `rst` input 1: synchronous, active-high reset.
- `ena` input 1: design selected; when 0, new requests are ignored.
- `ui_in` input 8: [7]=req, [6]=wr (1=write), [2:0]=addr, [5:3] ignored.
- `uio_in` input 8: write data.
- `uo_out` output 8: {reg0[6:0], ack}.
- `uio_out` output 8: read data.
- `uio_oe` output 8: 8'hFF while driving read data, else 8'h00.

## Operation
- Register map:
  - Addresses 0–5: R/W bytes.
  - Address 6: RO transaction counter.
  - Address 7: RO `ID_VALUE`.
  - Writes to 6 and 7 are discarded but still acknowledged.
- `req` passes through a `SYNC_STAGES` synchronizer, giving `req_s`. `wr`, `addr` and `uio_in` are not synchronized. The host holds them stable from req rise until ack rise.
- FSM states: IDLE, EXEC, ACK.
  - IDLE → EXEC when `req_s`=1 and `ena`=1. On this transition the block latches wr, addr and wdata.
  - EXEC → ACK unconditionally. At this edge:
    - a write updates the register;
    - a read loads `uio_out` from the register;
    - the counter increments, wrapping 255→0.
    - Read data is the value before that edge. Reading address 6 returns the count prior to the current transaction.
  - ACK → IDLE when `req_s`=0. Otherwise the FSM holds in ACK.
- IDLE is level-sensitive: if req is still high on return to IDLE, a new transaction starts. If req is high at reset release, a transaction starts once it is synchronized.
- All outputs are registered.
  - `ack` = (state==ACK).
  - `uio_oe` = 8'hFF iff state==ACK and the latched op is a read.
  - `uio_out` holds its last read value. It is don't-care while `uio_oe`=0.
- `ena`=0 in EXEC or ACK does not abort the transaction. `ena` only gates IDLE→EXEC.
- Reset values:
  - state IDLE; regs 0–5 = 0; counter 0; synchronizer flops 0.
  - `uo_out`=8'h00, `uio_out`=8'h00, `uio_oe`=8'h00.
- Reset mid-transaction: the next edge forces all reset values. There is no partial write; a write whose EXEC edge has not occurred is lost.

## Timing
- Edges are counted after the first `clk` edge that samples req=1 at the pin, with `SYNC_STAGES`=2:
  - edge 2: `req_s`=1;
  - edge 3: EXEC;
  - edge 4: ACK. `ack`=1, and for reads `uio_out`/`uio_oe` are valid.
- Request-to-ack latency is `SYNC_STAGES`+2 edges.
- Release: on the first edge sampling req=0, `ack` and `uio_oe` fall `SYNC_STAGES`+1 edges later.
- A register write is visible on `uo_out[7:1]` from the same edge as `ack` rise.
- Throughput is at most one transaction per 2·`SYNC_STAGES`+3 cycles.

## Structure
- Package `tt_uio_pkg` holds:
  - the state enum (IDLE/EXEC/ACK);
  - address constants `ADDR_CNT`=3'd6 and `ADDR_ID`=3'd7;
  - bit-index constants for req/wr/addr within `ui_in`.
- Sub-module `tt_sync2`: parameterized-depth synchronizer with synchronous active-high reset. It is reused for future asynchronous pin inputs.

## Test plan
- Reset state:
  - Hold `rst` 3 cycles. Expect all outputs 0.
  - Then read addr 7. Expect `uio_out`=8'hA5 and `uio_oe`=8'hFF while ack=1.
- Write then read back:
  - Write 8'h3C to addr 0. Expect ack on edge 4 and `uo_out`=8'h79; after release, `uo_out`=8'h78.
  - Read addr 0. Expect `uio_out`=8'h3C.
  - After req drops, expect `uio_oe`=0 and ack=0 exactly 3 edges later.
- Read-only protection: write 8'h00 to addr 7, then read addr 7. Expect 8'hA5. The counter still advances for both transactions.
- Counter wrap:
  - From reset, do 255 writes to addr 1, then read addr 6. Expect 8'hFF.
  - Read addr 6 again. Expect 8'h00.
- ena gating: `ena`=0 with req held high for 10 cycles gives no ack. Raising `ena` gives ack 2 edges later.
- Reset mid-ACK:
  - Write 8'h55 to addr 0 and wait for ack=1.
  - Assert `rst` for 1 cycle. Expect ack, `uo_out` and `uio_oe` all 0 on the next edge.
  - Then read addr 0. Expect 8'h00.
